// File: rtl/digi_ota_pkg.sv
// Shared types and default parameter values for the digital OTA array.
package digi_ota_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_OPEN   = 2'b01,
    MODE_FOLLOW = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam int unsigned DefNCh         = 2;
  localparam int unsigned DefAccW        = 6;
  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefHyst        = 4;
  localparam int unsigned DefSettleCyc   = 8;

endpackage

// File: rtl/digi_ota_ch.sv
// One OTA channel: input synchroniser, registered drive, saturating node
// accumulator, hysteretic output comparator and settle counter.
module digi_ota_ch
  import digi_ota_pkg::*;
#(
  parameter int unsigned ACC_W       = DefAccW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned HYST        = DefHyst,
  parameter int unsigned SETTLE_CYC  = DefSettleCyc
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic             en,
  input  logic             vip,
  input  logic             vin,
  output logic             out,
  output logic             drive_en,
  output logic             drive_val,
  output logic             settled,
  output logic [ACC_W-1:0] acc
);

  localparam int unsigned Mid  = 1 << (ACC_W - 1);
  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);

  localparam logic [ACC_W-1:0] AccMid  = ACC_W'(Mid);
  localparam logic [ACC_W-1:0] AccMax  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] SetTh   = ACC_W'(Mid + HYST);
  localparam logic [ACC_W-1:0] ClrTh   = ACC_W'(Mid - HYST);
  localparam logic [CntW-1:0]  CntMax  = CntW'(SETTLE_CYC);

  logic [SYNC_STAGES-1:0] vip_sync_q, vip_sync_d;
  logic [SYNC_STAGES-1:0] vin_sync_q, vin_sync_d;
  logic                   drive_en_q, drive_en_d;
  logic                   drive_val_q, drive_val_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   out_q, out_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic vip_s, vin_s, vin_eff, active;

  assign vip_s = vip_sync_q[SYNC_STAGES-1];
  assign vin_s = vin_sync_q[SYNC_STAGES-1];

  always_comb begin
    vip_sync_d  = {vip_sync_q[SYNC_STAGES-2:0], vip};
    vin_sync_d  = {vin_sync_q[SYNC_STAGES-2:0], vin};

    active      = en && ((mode == MODE_OPEN) || (mode == MODE_FOLLOW));
    vin_eff     = (mode == MODE_FOLLOW) ? out_q : vin_s;
    drive_en_d  = active && (vip_s ^ vin_eff);
    drive_val_d = drive_en_d && vip_s;

    // The node only moves on the registered drive, so a mode change cannot glitch it.
    acc_d = acc_q;
    if (en && drive_en_q) begin
      if (drive_val_q) begin
        if (acc_q != AccMax) acc_d = acc_q + ACC_W'(1);
      end else begin
        if (acc_q != '0) acc_d = acc_q - ACC_W'(1);
      end
    end

    out_d = out_q;
    if (en) begin
      if (acc_q >= SetTh) begin
        out_d = 1'b1;
      end else if (acc_q < ClrTh) begin
        out_d = 1'b0;
      end
    end

    if (!en || drive_en_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vip_sync_q  <= '0;
      vin_sync_q  <= '0;
      drive_en_q  <= 1'b0;
      drive_val_q <= 1'b0;
      acc_q       <= AccMid;
      out_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      vip_sync_q  <= vip_sync_d;
      vin_sync_q  <= vin_sync_d;
      drive_en_q  <= drive_en_d;
      drive_val_q <= drive_val_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out       = out_q;
  assign drive_en  = drive_en_q;
  assign drive_val = drive_val_q;
  assign settled   = (cnt_q == CntMax);
  assign acc       = acc_q;

endmodule

// File: rtl/digi_ota_array.sv
// Array of independent OTA channels sharing only the operating mode.
module digi_ota_array
  import digi_ota_pkg::*;
#(
  parameter int unsigned N_CH        = DefNCh,
  parameter int unsigned ACC_W       = DefAccW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned HYST        = DefHyst,
  parameter int unsigned SETTLE_CYC  = DefSettleCyc
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       vip,
  input  logic [N_CH-1:0]       vin,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       drive_en,
  output logic [N_CH-1:0]       drive_val,
  output logic [N_CH-1:0]       settled,
  output logic [N_CH*ACC_W-1:0] acc_flat
);

  mode_e mode_q;
  assign mode_q = mode_e'(mode);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    digi_ota_ch #(
      .ACC_W      (ACC_W),
      .SYNC_STAGES(SYNC_STAGES),
      .HYST       (HYST),
      .SETTLE_CYC (SETTLE_CYC)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode_q),
      .en       (en[i]),
      .vip      (vip[i]),
      .vin      (vin[i]),
      .out      (out[i]),
      .drive_en (drive_en[i]),
      .drive_val(drive_val[i]),
      .settled  (settled[i]),
      .acc      (acc_flat[i*ACC_W +: ACC_W])
    );
  end

endmodule
